ex_stage_pipe: RTL and testbench

EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

---
 rtl/ex_stage_pipe.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// ---------------------------------------------------------------------------
// ex_stage_pipe
//
// Execute stage of a small in-order pipeline.
//
// The ID/EX register holds one decoded instruction. The ALU result, the
// write target and the pass-through controls for that instruction are
// computed from it and loaded into the EX/MEM register. The EX/MEM register
// drives every out_* port directly. Both registers use a valid/ready
// handshake, so back-to-back instructions flow at one per cycle with a
// two-edge latency while out_ready is held high.
//
// Build option:
//   EX_STAGE_FWD_EN - when defined, operand A and the B/store operand can be
//                     taken from the MEM or WB forwarding paths (fwd_a/fwd_b:
//                     0 = register, 1 = mem_fwd_data, 2 = wb_fwd_data,
//                     3 = register). When undefined, the forwarding inputs
//                     are ignored and the register operands are always used.
//
// Ports:
//   clk, reset                  clock (rising edge); synchronous active-high
//                               reset
//   in_valid / in_ready         upstream (ID) handshake
//   in_pc, in_rd1, in_rd2,      instruction PC, register operands and
//   in_imm                      immediate
//   in_rs, in_rt, in_rd         register addresses
//   in_alu_op, in_alu_src,      ALU operation, immediate select, load-high
//   in_is_lhi, in_reg_dest      immediate, and write-target select
//   in_mem_read, in_mem_write,  controls passed through to MEM/WB
//   in_wb_src, in_reg_write
//   flush                       squash the ID/EX entry and any beat offered
//                               in the same cycle
//   fwd_a, fwd_b                forwarding selects for operands A and B
//   mem_fwd_data, wb_fwd_data   forwarded values from MEM and WB
//   idex_rs, idex_rt            ID/EX source addresses for the hazard unit
//   out_valid / out_ready       downstream (MEM) handshake
//   out_pc, out_alu,            PC, ALU result and store data
//   out_store_data
//   out_wtarget                 destination register address
//   out_mem_read, out_mem_write, out_reg_write, out_wb_src
//                               pass-through controls
//   out_overflow                signed overflow of ADD/SUB
// ---------------------------------------------------------------------------
module ex_stage_pipe #(
  parameter int WORD_SIZE = 16,
  parameter int RA_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_pc,
  input  logic [WORD_SIZE-1:0] in_rd1,
  input  logic [WORD_SIZE-1:0] in_rd2,
  input  logic [WORD_SIZE-1:0] in_imm,
  input  logic [RA_W-1:0]      in_rs,
  input  logic [RA_W-1:0]      in_rt,
  input  logic [RA_W-1:0]      in_rd,
  input  logic [2:0]           in_alu_op,
  input  logic                 in_alu_src,
  input  logic                 in_is_lhi,
  input  logic                 in_reg_dest,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic [1:0]           in_wb_src,
  input  logic                 in_reg_write,

  input  logic                 flush,
  input  logic [1:0]           fwd_a,
  input  logic [1:0]           fwd_b,
  input  logic [WORD_SIZE-1:0] mem_fwd_data,
  input  logic [WORD_SIZE-1:0] wb_fwd_data,
  output logic [RA_W-1:0]      idex_rs,
  output logic [RA_W-1:0]      idex_rt,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_pc,
  output logic [WORD_SIZE-1:0] out_alu,
  output logic [WORD_SIZE-1:0] out_store_data,
  output logic [RA_W-1:0]      out_wtarget,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_reg_write,
  output logic [1:0]           out_wb_src,
  output logic                 out_overflow
);

  localparam int HALF = WORD_SIZE / 2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_NOT = 3'd4;
  localparam logic [2:0] ALU_NEG = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  // Returns {overflow, result}. All results wrap modulo 2^WORD_SIZE; only
  // ADD and SUB report signed overflow.
  function automatic logic [WORD_SIZE:0] alu_exec(
    input logic [2:0]                  op,
    input logic signed [WORD_SIZE-1:0] a,
    input logic signed [WORD_SIZE-1:0] b
  );
    logic signed [WORD_SIZE-1:0] r;
    logic                        ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        r   = a + b;
        ovf = (a[WORD_SIZE-1] == b[WORD_SIZE-1]) &&
              (r[WORD_SIZE-1] != a[WORD_SIZE-1]);
      end
      ALU_SUB: begin
        r   = a - b;
        ovf = (a[WORD_SIZE-1] != b[WORD_SIZE-1]) &&
              (r[WORD_SIZE-1] != a[WORD_SIZE-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOT: r = ~a;
      ALU_NEG: r = -a;
      ALU_SHL: r = a <<< 1;
      ALU_SRA: r = a >>> 1;
      default: r = '0;
    endcase
    return {ovf, r};
  endfunction

  // Load-high-immediate: low half of the immediate moved to the upper half.
  function automatic logic [WORD_SIZE-1:0] lhi_word(
    input logic [WORD_SIZE-1:0] imm
  );
    return {imm[HALF-1:0], {HALF{1'b0}}};
  endfunction

  // ID/EX register
  logic                        r_vld_p1;
  logic [WORD_SIZE-1:0]        r_pc_p1;
  logic signed [WORD_SIZE-1:0] r_rd1_p1;
  logic signed [WORD_SIZE-1:0] r_rd2_p1;
  logic signed [WORD_SIZE-1:0] r_imm_p1;
  logic [RA_W-1:0]             r_rs_p1;
  logic [RA_W-1:0]             r_rt_p1;
  logic [RA_W-1:0]             r_rd_p1;
  logic [2:0]                  r_alu_op_p1;
  logic                        r_alu_src_p1;
  logic                        r_is_lhi_p1;
  logic                        r_reg_dest_p1;
  logic                        r_mem_read_p1;
  logic                        r_mem_write_p1;
  logic [1:0]                  r_wb_src_p1;
  logic                        r_reg_write_p1;

  // EX/MEM register
  logic                        r_vld_p2;
  logic [WORD_SIZE-1:0]        r_pc_p2;
  logic [WORD_SIZE-1:0]        r_alu_p2;
  logic [WORD_SIZE-1:0]        r_store_p2;
  logic [RA_W-1:0]             r_wtarget_p2;
  logic                        r_mem_read_p2;
  logic                        r_mem_write_p2;
  logic                        r_reg_write_p2;
  logic [1:0]                  r_wb_src_p2;
  logic                        r_ovf_p2;

  logic                        w_advance;
  logic                        w_accept;
  logic                        w_load_ex;
  logic signed [WORD_SIZE-1:0] w_opa;
  logic signed [WORD_SIZE-1:0] w_fwdb;
  logic signed [WORD_SIZE-1:0] w_opb;
  logic [WORD_SIZE:0]          w_alu_full;
  logic [WORD_SIZE-1:0]        w_result;
  logic                        w_ovf;
  logic [RA_W-1:0]             w_wtarget;

  // Handshake: the ID/EX entry moves on whenever EX/MEM is empty or being
  // drained this cycle; ID/EX can take a new beat if it is empty or moving.
  assign w_advance = r_vld_p1 & (~r_vld_p2 | out_ready);
  assign in_ready  = ~r_vld_p1 | w_advance;
  assign w_accept  = in_valid & in_ready & ~flush;
  // A flushed instruction is squashed: it leaves ID/EX but never reaches
  // EX/MEM, whose contents are left untouched by flush.
  assign w_load_ex = w_advance & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1       <= 1'b0;
      r_pc_p1        <= '0;
      r_rd1_p1       <= '0;
      r_rd2_p1       <= '0;
      r_imm_p1       <= '0;
      r_rs_p1        <= '0;
      r_rt_p1        <= '0;
      r_rd_p1        <= '0;
      r_alu_op_p1    <= '0;
      r_alu_src_p1   <= 1'b0;
      r_is_lhi_p1    <= 1'b0;
      r_reg_dest_p1  <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      r_wb_src_p1    <= '0;
      r_reg_write_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1       <= 1'b1;
      r_pc_p1        <= in_pc;
      r_rd1_p1       <= in_rd1;
      r_rd2_p1       <= in_rd2;
      r_imm_p1       <= in_imm;
      r_rs_p1        <= in_rs;
      r_rt_p1        <= in_rt;
      r_rd_p1        <= in_rd;
      r_alu_op_p1    <= in_alu_op;
      r_alu_src_p1   <= in_alu_src;
      r_is_lhi_p1    <= in_is_lhi;
      r_reg_dest_p1  <= in_reg_dest;
      r_mem_read_p1  <= in_mem_read;
      r_mem_write_p1 <= in_mem_write;
      r_wb_src_p1    <= in_wb_src;
      r_reg_write_p1 <= in_reg_write;
    end else if (w_advance || flush) begin
      // Fields are kept so idex_rs/idex_rt stay defined while empty.
      r_vld_p1 <= 1'b0;
    end
  end

  // ---- EX: operand selection and ALU (ID/EX -> EX/MEM) ----
`ifdef EX_STAGE_FWD_EN
  function automatic logic [WORD_SIZE-1:0] fwd_sel(
    input logic [1:0]           sel,
    input logic [WORD_SIZE-1:0] reg_val,
    input logic [WORD_SIZE-1:0] mem_val,
    input logic [WORD_SIZE-1:0] wb_val
  );
    case (sel)
      2'd1:    return mem_val;
      2'd2:    return wb_val;
      default: return reg_val;
    endcase
  endfunction

  assign w_opa  = fwd_sel(fwd_a, r_rd1_p1, mem_fwd_data, wb_fwd_data);
  assign w_fwdb = fwd_sel(fwd_b, r_rd2_p1, mem_fwd_data, wb_fwd_data);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_a, fwd_b, mem_fwd_data, wb_fwd_data};
  assign w_opa        = r_rd1_p1;
  assign w_fwdb       = r_rd2_p1;
`endif

  assign w_opb      = r_alu_src_p1 ? r_imm_p1 : w_fwdb;
  assign w_alu_full = alu_exec(r_alu_op_p1, w_opa, w_opb);
  assign w_result   = r_is_lhi_p1 ? lhi_word(r_imm_p1) : w_alu_full[WORD_SIZE-1:0];
  assign w_ovf      = ~r_is_lhi_p1 & w_alu_full[WORD_SIZE];
  assign w_wtarget  = r_reg_dest_p1 ? r_rt_p1 : r_rd_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2       <= 1'b0;
      r_pc_p2        <= '0;
      r_alu_p2       <= '0;
      r_store_p2     <= '0;
      r_wtarget_p2   <= '0;
      r_mem_read_p2  <= 1'b0;
      r_mem_write_p2 <= 1'b0;
      r_reg_write_p2 <= 1'b0;
      r_wb_src_p2    <= '0;
      r_ovf_p2       <= 1'b0;
    end else if (w_load_ex) begin
      r_vld_p2       <= 1'b1;
      r_pc_p2        <= r_pc_p1;
      r_alu_p2       <= w_result;
      r_store_p2     <= w_fwdb;
      r_wtarget_p2   <= w_wtarget;
      r_mem_read_p2  <= r_mem_read_p1;
      r_mem_write_p2 <= r_mem_write_p1;
      r_reg_write_p2 <= r_reg_write_p1;
      r_wb_src_p2    <= r_wb_src_p1;
      r_ovf_p2       <= w_ovf;
    end else if (out_ready) begin
      r_vld_p2 <= 1'b0;
    end
  end

  // ---- EX/MEM outputs ----
  assign out_valid      = r_vld_p2;
  assign out_pc         = r_pc_p2;
  assign out_alu        = r_alu_p2;
  assign out_store_data = r_store_p2;
  assign out_wtarget    = r_wtarget_p2;
  assign out_mem_read   = r_mem_read_p2;
  assign out_mem_write  = r_mem_write_p2;
  assign out_reg_write  = r_reg_write_p2;
  assign out_wb_src     = r_wb_src_p2;
  assign out_overflow   = r_ovf_p2;

  assign idex_rs = r_rs_p1;
  assign idex_rt = r_rt_p1;

endmodule

// File: tb/tb_ex_stage_pipe.sv
`timescale 1ns/1ps
module tb_ex_stage_pipe;

  localparam int W  = 16;
  localparam int RA = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_pc, in_rd1, in_rd2, in_imm;
  logic [RA-1:0] in_rs, in_rt, in_rd;
  logic [2:0]    in_alu_op;
  logic          in_alu_src, in_is_lhi, in_reg_dest;
  logic          in_mem_read, in_mem_write, in_reg_write;
  logic [1:0]    in_wb_src;
  logic          flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [W-1:0]  mem_fwd_data, wb_fwd_data;
  logic [RA-1:0] idex_rs, idex_rt;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_pc, out_alu, out_store_data;
  logic [RA-1:0] out_wtarget;
  logic          out_mem_read, out_mem_write, out_reg_write, out_overflow;
  logic [1:0]    out_wb_src;

  always #5 clk = ~clk;

  ex_stage_pipe #(.WORD_SIZE(W), .RA_W(RA)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_is_lhi(in_is_lhi),
    .in_reg_dest(in_reg_dest), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_wb_src(in_wb_src),
    .in_reg_write(in_reg_write),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
    .idex_rs(idex_rs), .idex_rt(idex_rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu(out_alu), .out_store_data(out_store_data),
    .out_wtarget(out_wtarget), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_wb_src(out_wb_src), .out_overflow(out_overflow)
  );

  typedef struct {
    logic [2:0]    op;
    logic          src, lhi, rdst;
    logic [W-1:0]  rd1, rd2, imm;
    logic [RA-1:0] rs, rt, rd;
    logic [1:0]    fa, fb;
    logic [W-1:0]  mfd, wfd;
    logic [W-1:0]  e_alu;
    logic          e_ovf;
    logic [RA-1:0] e_wt;
    logic [W-1:0]  e_st;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_miss = 0;

`ifdef EX_STAGE_FWD_EN
  localparam logic [W-1:0] E13_ALU = 16'h000D;
  localparam logic [W-1:0] E14_ALU = 16'h0101;
  localparam logic [W-1:0] E14_ST  = 16'h0100;
  localparam logic [W-1:0] E16_ST  = 16'h0007;
`else
  localparam logic [W-1:0] E13_ALU = 16'hFFFE;
  localparam logic [W-1:0] E14_ALU = 16'h0003;
  localparam logic [W-1:0] E14_ST  = 16'h0002;
  localparam logic [W-1:0] E16_ST  = 16'h0003;
`endif

  function automatic vec_t mk(
    input logic [2:0] op, input logic src, input logic lhi, input logic rdst,
    input logic [W-1:0] rd1, input logic [W-1:0] rd2, input logic [W-1:0] imm,
    input logic [RA-1:0] rs, input logic [RA-1:0] rt, input logic [RA-1:0] rd,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [W-1:0] mfd, input logic [W-1:0] wfd,
    input logic [W-1:0] e_alu, input logic e_ovf, input logic [RA-1:0] e_wt,
    input logic [W-1:0] e_st);
    vec_t v;
    v.op = op; v.src = src; v.lhi = lhi; v.rdst = rdst;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.rs = rs; v.rt = rt; v.rd = rd; v.fa = fa; v.fb = fb;
    v.mfd = mfd; v.wfd = wfd;
    v.e_alu = e_alu; v.e_ovf = e_ovf; v.e_wt = e_wt; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = '0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_alu_op = '0; in_alu_src = 0;
    in_is_lhi = 0; in_reg_dest = 0; in_mem_read = 0; in_mem_write = 0;
    in_wb_src = '0; in_reg_write = 0; flush = 0; fwd_a = '0; fwd_b = '0;
    mem_fwd_data = '0; wb_fwd_data = '0;
  endtask

  task automatic drive_vec(input vec_t v, input int i);
    logic [4:0] ctl;
    ctl = i[4:0];
    in_pc = 16'h0100 + i[15:0];
    in_rd1 = v.rd1; in_rd2 = v.rd2; in_imm = v.imm;
    in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_alu_op = v.op; in_alu_src = v.src; in_is_lhi = v.lhi; in_reg_dest = v.rdst;
    in_mem_read = ctl[0]; in_mem_write = ctl[1]; in_wb_src = ctl[3:2];
    in_reg_write = ctl[4];
    fwd_a = v.fa; fwd_b = v.fb; mem_fwd_data = v.mfd; wb_fwd_data = v.wfd;
  endtask

  // Plain ADD beat: result equals pc (rd1 = pc, rd2 = 0), tagged by rs.
  task automatic set_beat(input logic [W-1:0] pc, input logic [RA-1:0] rs);
    idle_inputs();
    in_pc = pc; in_rd1 = pc; in_rs = rs; in_valid = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           op    src lhi rdst rd1       rd2       imm       rs rt rd fa fb mfd       wfd       e_alu     ovf wt e_st
    vecs[0]  = mk(3'd0, 0, 0, 0, 16'h7FFF, 16'h0001, 16'h0000, 1, 2, 3, 0, 0, 16'h0000, 16'h0000, 16'h8000, 1, 3, 16'h0001);
    vecs[1]  = mk(3'd1, 0, 0, 0, 16'h8000, 16'h0001, 16'h0000, 2, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h7FFF, 1, 0, 16'h0001);
    vecs[2]  = mk(3'd1, 0, 0, 1, 16'h0005, 16'h0007, 16'h0000, 3, 2, 1, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 0, 2, 16'h0007);
    vecs[3]  = mk(3'd2, 0, 0, 0, 16'hF0F0, 16'h3C3C, 16'h0000, 0, 1, 2, 0, 0, 16'h0000, 16'h0000, 16'h3030, 0, 2, 16'h3C3C);
    vecs[4]  = mk(3'd3, 0, 0, 0, 16'hF0F0, 16'h0F01, 16'h0000, 1, 3, 1, 0, 0, 16'h0000, 16'h0000, 16'hFFF1, 0, 1, 16'h0F01);
    vecs[5]  = mk(3'd4, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 2, 0, 3, 0, 0, 16'h0000, 16'h0000, 16'hEDCB, 0, 3, 16'h0000);
    vecs[6]  = mk(3'd5, 0, 0, 0, 16'h0001, 16'hAAAA, 16'h0000, 3, 3, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 16'hAAAA);
    vecs[7]  = mk(3'd5, 0, 0, 0, 16'h8000, 16'h0000, 16'h0000, 0, 1, 2, 0, 0, 16'h0000, 16'h0000, 16'h8000, 0, 2, 16'h0000);
    vecs[8]  = mk(3'd6, 0, 0, 0, 16'hC001, 16'h0000, 16'h0000, 1, 1, 1, 0, 0, 16'h0000, 16'h0000, 16'h8002, 0, 1, 16'h0000);
    vecs[9]  = mk(3'd7, 0, 0, 0, 16'h8004, 16'h0000, 16'h0000, 2, 2, 3, 0, 0, 16'h0000, 16'h0000, 16'hC002, 0, 3, 16'h0000);
    vecs[10] = mk(3'd7, 0, 0, 0, 16'h4004, 16'h0000, 16'h0000, 3, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h2002, 0, 0, 16'h0000);
    vecs[11] = mk(3'd0, 1, 0, 0, 16'h0010, 16'h5555, 16'hFFFF, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h000F, 0, 1, 16'h5555);
    vecs[12] = mk(3'd0, 0, 1, 1, 16'h7FFF, 16'h0001, 16'h00AB, 0, 2, 1, 0, 0, 16'h0000, 16'h0000, 16'hAB00, 0, 2, 16'h0001);
    vecs[13] = mk(3'd1, 0, 0, 0, 16'h0001, 16'h0003, 16'h0000, 1, 0, 2, 1, 0, 16'h0010, 16'h0000, E13_ALU,  0, 2, 16'h0003);
    vecs[14] = mk(3'd0, 0, 0, 0, 16'h0001, 16'h0002, 16'h0000, 2, 3, 3, 0, 2, 16'h0000, 16'h0100, E14_ALU,  0, 3, E14_ST);
    vecs[15] = mk(3'd0, 0, 0, 0, 16'h0004, 16'h0001, 16'h0000, 3, 1, 0, 3, 0, 16'h9999, 16'h0000, 16'h0005, 0, 0, 16'h0001);
    vecs[16] = mk(3'd1, 1, 0, 1, 16'h0020, 16'h0003, 16'h0008, 0, 3, 2, 0, 1, 16'h0007, 16'h0000, 16'h0018, 0, 3, E16_ST);
    vecs[17] = mk(3'd0, 0, 0, 0, 16'h8000, 16'h8000, 16'h0000, 1, 2, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h8000);
    vecs[18] = mk(3'd6, 0, 0, 0, 16'h4000, 16'h0000, 16'h0000, 2, 1, 2, 0, 0, 16'h0000, 16'h0000, 16'h8000, 0, 2, 16'h0000);

    // Reset
    idle_inputs();
    out_ready = 1;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_alu", out_alu, 0);
    chk("rst out_pc", out_pc, 0);
    chk("rst idex_rs", idex_rs, 0);
    chk("rst out_wtarget", out_wtarget, 0);

    // Table: each vector goes in alone and must appear at the second edge.
    for (int i = 0; i < NV; i++) begin
      logic [4:0] ctl;
      ctl = i[4:0];
      @(negedge clk);
      drive_vec(vecs[i], i);
      in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      chk($sformatf("v%0d edge1 out_valid", i), out_valid, 0);
      chk($sformatf("v%0d idex_rs", i), idex_rs, vecs[i].rs);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d out_alu", i), out_alu, vecs[i].e_alu);
      chk($sformatf("v%0d out_overflow", i), out_overflow, vecs[i].e_ovf);
      chk($sformatf("v%0d out_wtarget", i), out_wtarget, vecs[i].e_wt);
      chk($sformatf("v%0d out_store_data", i), out_store_data, vecs[i].e_st);
      chk($sformatf("v%0d out_pc", i), out_pc, 16'h0100 + i[15:0]);
      chk($sformatf("v%0d ctl", i),
          {out_mem_read, out_mem_write, out_wb_src, out_reg_write},
          {ctl[0], ctl[1], ctl[3:2], ctl[4]});
      chk($sformatf("v%0d idex_rt held", i), idex_rt, vecs[i].rt);
    end

    // Drain, then backpressure with three beats offered.
    @(negedge clk);
    idle_inputs();
    out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp start out_valid", out_valid, 0);
    out_ready = 0;
    set_beat(16'hA000, 2'd1);
    @(negedge clk);
    set_beat(16'hB000, 2'd2);
    @(negedge clk);
    set_beat(16'hC000, 2'd3);
    #1;
    chk("bp in_ready 3rd offer", in_ready, 0);
    chk("bp out_valid", out_valid, 1);
    chk("bp out_pc A", out_pc, 16'hA000);
    @(negedge clk);
    chk("bp hold out_pc A", out_pc, 16'hA000);
    chk("bp hold idex B", idex_rs, 2);
    chk("bp hold in_ready", in_ready, 0);
    @(negedge clk);
    chk("bp hold2 out_pc A", out_pc, 16'hA000);
    out_ready = 1;
    #1;
    chk("bp release in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp out B valid", out_valid, 1);
    chk("bp out_pc B", out_pc, 16'hB000);
    chk("bp idex C", idex_rs, 3);
    @(posedge clk); #1;
    chk("bp out C valid", out_valid, 1);
    chk("bp out_pc C", out_pc, 16'hC000);
    chk("bp out_alu C", out_alu, 16'hC000);
    @(posedge clk); #1;
    chk("bp no dup", out_valid, 0);

    // Flush: one beat in ID/EX plus a new beat offered in the flush cycle.
    @(negedge clk);
    set_beat(16'hD000, 2'd1);
    @(posedge clk); #1;
    chk("fl D in idex", idex_rs, 1);
    chk("fl pre out_valid", out_valid, 0);
    @(negedge clk);
    set_beat(16'hE000, 2'd2);
    flush = 1;
    @(posedge clk); #1;
    chk("fl out_valid", out_valid, 0);
    chk("fl out_pc kept", out_pc, 16'hC000);
    chk("fl E dropped", idex_rs, 1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk("fl post out_valid", out_valid, 0);
    chk("fl post out_alu kept", out_alu, 16'hC000);
    chk("fl post in_ready", in_ready, 1);

    // Reset with beats in both registers and one offered.
    @(negedge clk);
    set_beat(16'h7FFF, 2'd3);
    in_rd2 = 16'h0001;
    out_ready = 0;
    @(negedge clk);
    set_beat(16'h0ABC, 2'd2);
    @(posedge clk); #1;
    chk("rs out_valid", out_valid, 1);
    chk("rs out_alu", out_alu, 16'h8000);
    chk("rs out_overflow", out_overflow, 1);
    chk("rs idex G", idex_rs, 2);
    @(negedge clk);
    set_beat(16'h5555, 2'd1);
    reset = 1;
    @(posedge clk); #1;
    chk("rs2 out_valid", out_valid, 0);
    chk("rs2 out_alu", out_alu, 0);
    chk("rs2 out_pc", out_pc, 0);
    chk("rs2 out_overflow", out_overflow, 0);
    chk("rs2 idex_rs", idex_rs, 0);
    @(negedge clk);
    reset = 0;
    idle_inputs();
    out_ready = 1;
    #1;
    chk("rs2 in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("rs2 nothing out", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
